// File: rtl/seven_seg_scanner.sv
// ============================================================================
// seven_seg_scanner
// Multiplexed 4-digit common-anode seven-segment driver for the digital clock.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_scanner #(
   parameter int REFRESH_DIV = 100_000,
   parameter int GUARD       = 16,
   parameter int BLINK_DIV   = 50_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] s1,
   input  logic [3:0] s2,
   input  logic [3:0] m1,
   input  logic [3:0] m2,
   input  logic [3:0] h1,
   input  logic [3:0] h2,
   input  logic       pos,
   input  logic       currentMode,
   input  logic       page,
   input  logic       blink_en,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int SW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] c_slotMax  = SW'(REFRESH_DIV - 1);
   localparam logic [SW-1:0] c_guard    = SW'(GUARD);
   localparam logic [BW-1:0] c_blinkMax = BW'(BLINK_DIV - 1);

   logic [SW-1:0] r_slotCnt;
   logic [1:0]    r_idx;
   logic [BW-1:0] r_blinkCnt;
   logic          r_phase;
   logic [3:0]    r_shS1, r_shS2, r_shM1, r_shM2, r_shH1, r_shH2;
   logic          r_shPage, r_shPos, r_shMode, r_shBlinkEn;

   logic          w_slotWrap;
   logic          w_frameLatch;
   logic          w_blinkWrap;
   logic          w_inGuard;
   logic [3:0]    w_digit;
   logic          w_edited;
   logic          w_blank;
   logic          w_colonLit;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'd0:    decode = 7'h40;
         4'd1:    decode = 7'h79;
         4'd2:    decode = 7'h24;
         4'd3:    decode = 7'h30;
         4'd4:    decode = 7'h19;
         4'd5:    decode = 7'h12;
         4'd6:    decode = 7'h02;
         4'd7:    decode = 7'h78;
         4'd8:    decode = 7'h00;
         4'd9:    decode = 7'h10;
         default: decode = 7'h3F;
      endcase
   endfunction

   always_comb begin
      w_slotWrap   = (r_slotCnt == c_slotMax);
      w_frameLatch = w_slotWrap && (r_idx == 2'd0);
      w_blinkWrap  = (r_blinkCnt == c_blinkMax);
      w_inGuard    = (r_slotCnt < c_guard);
      w_digit      = 4'd0;
      case (r_idx)
         2'd3: w_digit = r_shPage ? r_shM2 : r_shH2;
         2'd2: w_digit = r_shPage ? r_shM1 : r_shH1;
         2'd1: w_digit = r_shPage ? r_shS2 : r_shM2;
         2'd0: w_digit = r_shPage ? r_shS1 : r_shM1;
         default: w_digit = 4'd0;
      endcase
      // On the seconds page the hours field is off-screen, so pos=1 never blinks.
      w_edited   = r_shPage ? (!r_shPos && r_idx[1]) : (r_shPos == r_idx[1]);
      w_blank    = r_shBlinkEn && !r_phase && w_edited;
      w_colonLit = (r_idx == 2'd2) && (r_shMode || r_phase);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_slotCnt   <= '0;
         r_idx       <= 2'd3;
         r_blinkCnt  <= '0;
         r_phase     <= 1'b1;
         r_shS1      <= 4'd0;
         r_shS2      <= 4'd0;
         r_shM1      <= 4'd0;
         r_shM2      <= 4'd0;
         r_shH1      <= 4'd0;
         r_shH2      <= 4'd0;
         r_shPage    <= 1'b0;
         r_shPos     <= 1'b0;
         r_shMode    <= 1'b0;
         r_shBlinkEn <= 1'b0;
         an          <= 4'b1111;
         seg         <= 7'h7F;
         dp          <= 1'b1;
      end else begin
         r_slotCnt  <= w_slotWrap ? '0 : r_slotCnt + 1'b1;
         if (w_slotWrap)
            r_idx <= r_idx - 2'd1;
         r_blinkCnt <= w_blinkWrap ? '0 : r_blinkCnt + 1'b1;
         if (w_blinkWrap)
            r_phase <= ~r_phase;
         // Shadow capture only at frame boundaries keeps a frame tear-free.
         if (w_frameLatch) begin
            r_shS1      <= s1;
            r_shS2      <= s2;
            r_shM1      <= m1;
            r_shM2      <= m2;
            r_shH1      <= h1;
            r_shH2      <= h2;
            r_shPage    <= page;
            r_shPos     <= pos;
            r_shMode    <= currentMode;
            r_shBlinkEn <= blink_en;
         end
         if (w_inGuard) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
         end else begin
            an  <= ~(4'b0001 << r_idx);
            seg <= w_blank ? 7'h7F : decode(w_digit);
            dp  <= ~w_colonLit;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
// ============================================================================
// tb_seven_seg_scanner
// Frame-by-frame directed vectors feeding an expected-output queue.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_scanner;

   logic       clk;
   logic       rst;
   logic [3:0] s1, s2, m1, m2, h1, h2;
   logic       pos, currentMode, page, blink_en;
   logic [3:0] an;
   logic [6:0] seg;
   logic       dp;

   int tests = 0;
   int fails = 0;
   logic monEn = 1'b0;
   logic [11:0] expQ[$];

   typedef struct {
      logic [3:0] h2, h1, m2, m1, s2, s1;
      logic       pg, ps, md, be;
      logic [6:0] x3, x2, x1, x0;
      logic       dp2;
   } frame_t;

   frame_t tbl[17];

   seven_seg_scanner #(.REFRESH_DIV(4), .GUARD(1), .BLINK_DIV(64)) dut (
      .clk(clk), .rst(rst),
      .s1(s1), .s2(s2), .m1(m1), .m2(m2), .h1(h1), .h2(h2),
      .pos(pos), .currentMode(currentMode), .page(page), .blink_en(blink_en),
      .an(an), .seg(seg), .dp(dp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic pushFrame(input frame_t f);
      logic [6:0] x [4];
      x[3] = f.x3; x[2] = f.x2; x[1] = f.x1; x[0] = f.x0;
      for (int i = 3; i >= 0; i--)
         for (int k = 0; k < 3; k++)
            expQ.push_back({~(4'b0001 << i), x[i], (i == 2) ? f.dp2 : 1'b1});
   endtask

   task automatic applyInputs(input frame_t f);
      h2 = f.h2; h1 = f.h1; m2 = f.m2; m1 = f.m1; s2 = f.s2; s1 = f.s1;
      page = f.pg; pos = f.ps; currentMode = f.md; blink_en = f.be;
   endtask

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got {an,seg,dp}=%h, required %h", name, act, req);
      end
   endtask

   // Monitor: every lit-anode cycle consumes one expected entry
   always @(negedge clk) begin
      if (monEn) begin
         if (an == 4'hF) begin
            check("guard", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
         end else if (expQ.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL underflow: unexpected an=%h seg=%h dp=%b", an, seg, dp);
         end else begin
            check("slot", {an, seg, dp}, expQ.pop_front());
         end
      end
   end

   initial begin
      //              h2    h1    m2    m1    s2    s1   pg ps md be   idx3   idx2   idx1   idx0  dp2
      tbl[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 7'h40, 7'h40, 7'h40, 7'h40, 0};
      tbl[1]  = '{4'h1, 4'h2, 4'h5, 4'h8, 4'hC, 4'h3, 0, 0, 0, 0, 7'h79, 7'h24, 7'h12, 7'h00, 0};
      tbl[2]  = '{4'h1, 4'h2, 4'h5, 4'h8, 4'hC, 4'h3, 1, 0, 0, 0, 7'h12, 7'h00, 7'h3F, 7'h30, 0};
      tbl[3]  = '{4'h1, 4'h2, 4'h5, 4'h8, 4'hC, 4'h3, 0, 1, 1, 1, 7'h79, 7'h24, 7'h12, 7'h00, 0};
      tbl[4]  = '{4'h1, 4'h2, 4'h5, 4'h8, 4'hC, 4'h3, 0, 1, 1, 1, 7'h7F, 7'h7F, 7'h12, 7'h00, 0};
      tbl[5]  = tbl[4];
      tbl[6]  = '{4'h1, 4'h2, 4'h5, 4'h9, 4'hC, 4'h3, 0, 1, 1, 1, 7'h7F, 7'h7F, 7'h12, 7'h10, 0};
      tbl[7]  = tbl[6];
      tbl[8]  = '{4'h1, 4'h2, 4'h5, 4'h9, 4'hC, 4'h3, 0, 1, 1, 1, 7'h79, 7'h24, 7'h12, 7'h10, 0};
      tbl[9]  = '{4'h1, 4'h2, 4'h5, 4'h9, 4'hC, 4'h3, 1, 1, 0, 1, 7'h12, 7'h10, 7'h3F, 7'h30, 0};
      tbl[10] = tbl[9];
      tbl[11] = tbl[9];
      tbl[12] = '{4'h1, 4'h2, 4'h5, 4'h9, 4'hC, 4'h3, 1, 1, 0, 1, 7'h12, 7'h10, 7'h3F, 7'h30, 1};
      tbl[13] = tbl[12];
      tbl[14] = '{4'h1, 4'h2, 4'h5, 4'h9, 4'hC, 4'h3, 1, 0, 0, 1, 7'h7F, 7'h7F, 7'h3F, 7'h30, 1};
      tbl[15] = tbl[14];
      tbl[16] = '{4'h1, 4'h2, 4'h5, 4'h9, 4'hC, 4'h3, 1, 0, 0, 1, 7'h12, 7'h10, 7'h3F, 7'h30, 0};

      rst = 1'b1;
      applyInputs(tbl[0]);
      #12;
      check("reset state", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      pushFrame(tbl[0]);
      #10;
      rst   = 1'b0;
      monEn = 1'b1;

      // Next frame's inputs change while the index is 2, mid-frame.
      for (int f = 0; f < 17; f++) begin
         repeat (6) @(posedge clk);
         #1;
         if (f < 16) begin
            applyInputs(tbl[f + 1]);
            pushFrame(tbl[f + 1]);
         end
         repeat (10) @(posedge clk);
      end

      #7;
      monEn = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("pre-reset slot", {an, seg, dp}, {4'h7, 7'h12, 1'b1});
      rst = 1'b1;
      #1;
      check("async reset", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
      tests++;
      if (expQ.size() != 0) begin
         fails++;
         $display("FAIL queue drain: %0d entries left, required 0", expQ.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Consumes the six BCD digits, edit position and mode flag produced by the digital clock, and drives a 4-digit common-anode multiplexed seven-segment display.
- Shows one of two pages: HH.MM or MM.SS. The decimal point serves as the colon.
- Blinks the field currently being edited and suppresses ghosting with a guard interval.
- Latches digits once per scan frame so the display never tears mid-frame.

Parameters:
- REFRESH_DIV, 100_000: clk cycles each digit is driven (including guard); must be > GUARD.
- GUARD, 16: cycles at the start of each digit slot with all anodes off.
- BLINK_DIV, 50_000_000: clk cycles per blink-phase toggle.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- s1, s2, m1, m2, h1, h2  in  4 each  BCD digits (ones/tens of sec/min/hour)
- pos  in  1  edit field: 0 = minutes, 1 = hours
- currentMode  in  1  0 = CLOCK, 1 = ALARM
- page  in  1  0 = h2 h1 m2 m1, 1 = m2 m1 s2 s1
- blink_en  in  1  enables field blinking
- an  out  4  anode enables, active-low; an[3] is the leftmost digit
- seg  out  7  {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low

Behaviour:
- Reset, asserted asynchronously:
  - an = 4'b1111, seg = 7'h7F, dp = 1
  - slot counter = 0, digit index = 3, blink counter = 0, blink phase = 1 (visible)
  - shadow digits = 0, shadow page/pos/mode = 0
- Slot counter:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, digit index decrements 3→2→1→0→3.
- Frame latch:
  - Occurs on the cycle the slot counter wraps while the index goes 0→3.
  - Captures all six digits plus page, pos, currentMode and blink_en into shadow registers.
  - Outputs use only shadow values, so an input change appears at the next frame boundary (up to 4·REFRESH_DIV cycles later).
- Guard:
  - While slot counter < GUARD: an = 4'b1111, seg = 7'h7F, dp = 1.
  - Otherwise an = one-hot-low of the digit index (index 3 → 4'b0111).
  - All outputs are registered, so they lag the counter by one cycle.
- Digit mapping, index 3..0:
  - page 0: h2, h1, m2, m1
  - page 1: m2, m1, s2, s1
- Decode, seg hex values:
  - 0: 40, 1: 79, 2: 24, 3: 30, 4: 19
  - 5: 12, 6: 02, 7: 78, 8: 00, 9: 10
  - Any value ≥ 10 shows 3F (segment g only, i.e. a dash).
- Blink counter:
  - Counts 0..BLINK_DIV-1 and toggles blink phase on wrap.
  - Runs continuously from reset, independent of frame timing.
- Field blanking:
  - Blanking means seg = 7'h7F; the anode is still driven.
  - Applies when shadow blink_en = 1, blink phase = 0, and the digit belongs to the edited field.
  - Edited field, page 0: pos = 1 → indices 3,2 (hours); pos = 0 → indices 1,0 (minutes).
  - Edited field, page 1: pos = 0 → indices 3,2 (minutes); pos = 1 → nothing blinks, because hours are off-page.
- Colon (dp):
  - dp = 0 only on index 2 outside guard.
  - In CLOCK mode it follows blink phase (lit when phase = 1).
  - In ALARM mode it is lit steadily.
- Simultaneous events: when a frame latch and a blink toggle fall on the same cycle, both take effect; the new shadow values and the new phase apply together from the next cycle.
- Reset mid-frame: outputs blank immediately, asynchronously; the first frame after release displays shadow zeros until the first latch.
- No combinational path from any input to an, seg or dp.

Test Plan (REFRESH_DIV = 4, GUARD = 1, BLINK_DIV = 64):
- Reset scan:
  - Stimulus: assert rst mid-slot.
  - Required: an = F, seg = 7F, dp = 1 in the same cycle.
  - After release, with digits at 0: an sequence 7, B, D, E, each low for 3 of every 4 cycles with a 1-cycle all-off guard; seg = 40 while showing the shadow zeros.
- Page 0 at 12:58:
  - Stimulus: h2 = 1, h1 = 2, m2 = 5, m1 = 8, page = 0, blink_en = 0.
  - Required: after the first latch, seg per slot = 79, 24, 12, 00; dp = 0 only on the an = B slot.
- Page 1 and invalid digit:
  - Stimulus: page = 1, s2 = 4'hC, s1 = 3.
  - Required: the an = D slot shows 3F; the an = E slot shows 30.
- Blink hours in ALARM:
  - Stimulus: currentMode = 1, pos = 1, blink_en = 1, page = 0.
  - Required: the an = 7 and an = B slots show seg = 7F during the 64-cycle phase-0 window and normal digits in phase 1; dp stays lit steadily.
- Tear-free update:
  - Stimulus: change m1 from 8 to 9 while index = 2.
  - Required: seg stays 00 in the current frame's an = E slot; 10 appears only from the next frame.
- Off-page blink:
  - Stimulus: page = 1, pos = 1, blink_en = 1.
  - Required: no slot blanks in either blink phase; in CLOCK mode dp toggles every 64 cycles.
